hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Watches the instructions in D, E, M and the multiply/divide unit state, and generates the hold and bubble controls consumed by the PC register, the IF/ID register and the ID/EX register: `stall_D` drives the IF/ID hold enable (1 = hold), and `flush_E` drives the ID/EX synchronous clear. Holds a multi-cycle MDU busy counter, so stalls for `mfhi`/`mflo`/`mult`/`div` are decided here rather than in the datapath.

## Interface
- `MULT_LAT`, default 5: cycles `hi`/`lo` stay busy after `mult`/`multu` leaves E.
- `DIV_LAT`, default 10: cycles `hi`/`lo` stay busy after `div`/`divu` leaves E.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ins_D`  in  32  instruction currently in D (IF/ID output).
- `ins_E`  in  32  instruction currently in E (ID/EX output).
- `ins_M`  in  32  instruction currently in M.
- `stall_F`  out  1  hold PC (1 = hold).
- `stall_D`  out  1  hold IF/ID (1 = hold); wired to the IF/ID enable.
- `flush_E`  out  1  clear ID/EX to a nop on the next edge; wired to the ID/EX reset.
- `mdu_busy`  out  1  `hi`/`lo` not yet valid.

## Operation
- Decode per stage (opcode `[31:26]`, rs `[25:21]`, rt `[20:16]`, rd `[15:11]`, funct `[5:0]`). The all-zero word is a nop.
- **Destination `dst` and Tnew:**
  - loads (op 0x20, 0x21, 0x23, 0x24, 0x25): `dst` = rt, Tnew = 2 in E and 1 in M.
  - I-type ALU (op 0x08–0x0F): `dst` = rt, Tnew = 1 in E.
  - R-type (op 0) except `jr` (0x08), `mult`/`multu`/`div`/`divu` (0x18–0x1B) and `mthi`/`mtlo` (0x11, 0x13): `dst` = rd, Tnew = 1 in E.
  - `jal` (op 0x03): `dst` = 31, Tnew = 0.
  - All others: no `dst`.
  - `dst` = 0 never causes a hazard.
- **Tuse in D:**
  - `beq`/`bne` (op 0x04, 0x05): rs and rt, Tuse = 0.
  - `jr`/`jalr` (funct 0x08, 0x09): rs, Tuse = 0.
  - Every other instruction reading rs or rt: Tuse = 1.
  - Stores read rt with Tuse = 2.
- **Data stall:** asserted when a source of D matches E's `dst` and Tuse < Tnew_E, or matches M's `dst` and Tuse < Tnew_M.
- **MDU counter `cnt`** (4 bits, sized for `DIV_LAT`):
  - Loads `MULT_LAT` when E holds `mult`/`multu`, and `DIV_LAT` when E holds `div`/`divu`.
  - Otherwise decrements while nonzero and saturates at 0.
- `mdu_busy` = (E holds a start op) | (`cnt` != 0).
- **MDU stall:** D holds `mult`/`multu`/`div`/`divu`/`mfhi`/`mflo`/`mthi`/`mtlo` while `mdu_busy`.
- **Outputs:** `stall` = data stall | MDU stall; `stall_F` = `stall_D` = `flush_E` = `stall`. E and M are never held, so one bubble enters E each stalled cycle.
- **Simultaneous events:** a start op in E with an MDU op in D stalls D. No second start can reach E while `cnt` != 0.

## Timing
- All stall and flush outputs are combinational from the inputs and `cnt`, valid in the same cycle. No added latency.
- **Reset:** `cnt` clears to 0 immediately on `rst` falling.
  - While `rst` = 0, `stall_F`, `stall_D`, `flush_E` and `mdu_busy` are forced to 0.
  - Asserting reset mid-busy abandons the count. After release, `mdu_busy` = 0 unless E holds a start op.
- **MDU timing:** with a start op in E in cycle t, `cnt` = N in cycle t+1, then decrements to 1 in cycle t+N. `mdu_busy` is 1 for cycles t..t+N. An MDU op in D during that window is released in cycle t+N+1.
- **Load-use timing:** a load in E with its consumer in D gives one stall cycle. A branch whose operand comes from a load in E gives two stall cycles.

## Configuration
- `HAZARD_STAT_EN` defined:
  - adds output `stall_cnt` (out, 32 bits), reset to 0;
  - increments on every cycle with `stall` = 1 and wraps from 0xFFFFFFFF to 0;
  - adds input `stat_clr` (in, 1), a synchronous clear with priority over increment.
- `HAZARD_STAT_EN` undefined: neither port exists and no counter logic is present.

## Test plan
- Load-use: `lw $2,0($0)` in E, `addu $3,$2,$4` in D -> `stall_D` = `flush_E` = 1 for exactly 1 cycle, then 0.
- Branch after ALU op: `addu $5,$1,$1` in E, `beq $5,$0` in D -> stall 1 cycle. Same with `lw $5` -> stall 2 cycles.
- `$0` destination: `lw $0,0($0)` in E, `addu $3,$0,$0` in D -> no stall.
- MDU: `div` enters E at cycle t, `mflo` follows in D -> `mdu_busy` = 1 for cycles t..t+10, D stalled for 10 cycles, `mflo` enters E at t+12.
- Reset mid-busy: `mult` in E, drive `rst` = 0 two cycles later -> `cnt` = 0 and all outputs 0 immediately. After release with nops, `mdu_busy` = 0.
- With `HAZARD_STAT_EN`: preload `stall_cnt` near 0xFFFFFFFF via forced state, stall 3 cycles -> wraps to 1. Pulse `stat_clr` during a stall -> `stall_cnt` = 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generation for the five-stage MIPS pipeline.
//
// Watches the instructions in D, E and M and compares when D needs each source
// register (Tuse) with when the producer in E or M will have its result ready
// (Tnew). It also owns the multiply/divide busy counter, so D is held for
// hi/lo accesses while an MDU operation is still running.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ins_D      instruction at the IF/ID output
//   ins_E      instruction at the ID/EX output
//   ins_M      instruction in M
//   stall_F    hold the PC (1 = hold)
//   stall_D    hold IF/ID (1 = hold)
//   flush_E    clear ID/EX to a nop on the next edge
//   mdu_busy   hi/lo not yet valid
//   stat_clr   (HAZARD_STAT_EN only) synchronous clear of stall_cnt
//   stall_cnt  (HAZARD_STAT_EN only) count of stalled cycles, wraps at 2^32
//
// Optional feature: define HAZARD_STAT_EN to add the stall statistics counter.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_D,
  input  logic [31:0] ins_E,
  input  logic [31:0] ins_M,
`ifdef HAZARD_STAT_EN
  input  logic        stat_clr,
  output logic [31:0] stall_cnt,
`endif
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_E,
  output logic        mdu_busy
);

  localparam logic [3:0] MULT_N = 4'(MULT_LAT);
  localparam logic [3:0] DIV_N  = 4'(DIV_LAT);

  function automatic logic is_load(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
           (op == 6'h24) || (op == 6'h25);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  endfunction

  // Destination register; 0 means "no destination" and can never hazard.
  function automatic logic [4:0] dst_of(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] d;
    op = ins[31:26];
    fn = ins[5:0];
    d  = 5'd0;
    if (is_load(op) || (op[5:3] == 3'b001)) begin
      d = ins[20:16];
    end else if (op == 6'h00) begin
      // jr, mult/multu/div/divu and mthi/mtlo write no GPR
      if (!((fn == 6'h08) || (fn[5:2] == 4'b0110) ||
            (fn == 6'h11) || (fn == 6'h13))) begin
        d = ins[15:11];
      end
    end else if (op == 6'h03) begin
      d = 5'd31;
    end
    return d;
  endfunction

  // Cycles until the result exists, for the instruction sitting in E.
  function automatic logic [1:0] tnew_e(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (is_load(op))                               return 2'd2;
    else if ((op[5:3] == 3'b001) || (op == 6'h00)) return 2'd1;
    else                                           return 2'd0;
  endfunction

  // Only a load still has an outstanding result once it reaches M.
  function automatic logic [1:0] tnew_m(input logic [31:0] ins);
    return is_load(ins[31:26]) ? 2'd1 : 2'd0;
  endfunction

  // {reads, tuse} for the rs field of the instruction in D.
  function automatic logic [2:0] rs_use(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00)
      return ((fn == 6'h08) || (fn == 6'h09)) ? 3'b1_00 : 3'b1_01;
    else if ((op == 6'h04) || (op == 6'h05))
      return 3'b1_00;
    else if ((op == 6'h01) || (op == 6'h06) || (op == 6'h07) ||
             (op[5:3] == 3'b001) || is_load(op) || is_store(op))
      return 3'b1_01;
    else
      return 3'b0_00;
  endfunction

  // {reads, tuse} for the rt field; a store needs its data only in M.
  function automatic logic [2:0] rt_use(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if ((op == 6'h00) && (fn != 6'h08) && (fn != 6'h09)) return 3'b1_01;
    else if ((op == 6'h04) || (op == 6'h05))             return 3'b1_00;
    else if (is_store(op))                               return 3'b1_10;
    else                                                 return 3'b0_00;
  endfunction

  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [2:0] use_t,
                                      input logic [4:0] dst_e,
                                      input logic [1:0] tn_e,
                                      input logic [4:0] dst_m,
                                      input logic [1:0] tn_m);
    return use_t[2] && (src != 5'd0) &&
           (((src == dst_e) && (use_t[1:0] < tn_e)) ||
            ((src == dst_m) && (use_t[1:0] < tn_m)));
  endfunction

  logic [3:0] cnt;
  logic       mult_E;
  logic       div_E;
  logic       mdu_op_D;
  logic       data_stall;
  logic       stall;

  assign mult_E   = (ins_E[31:26] == 6'h00) && (ins_E[5:1] == 5'b01100);
  assign div_E    = (ins_E[31:26] == 6'h00) && (ins_E[5:1] == 5'b01101);
  // mfhi/mthi/mflo/mtlo (0x10-0x13) and mult/multu/div/divu (0x18-0x1B)
  assign mdu_op_D = (ins_D[31:26] == 6'h00) &&
                    ((ins_D[5:2] == 4'b0100) || (ins_D[5:2] == 4'b0110));

  always_comb begin
    data_stall = 1'b0;
    if (src_hazard(ins_D[25:21], rs_use(ins_D), dst_of(ins_E), tnew_e(ins_E),
                   dst_of(ins_M), tnew_m(ins_M)) ||
        src_hazard(ins_D[20:16], rt_use(ins_D), dst_of(ins_E), tnew_e(ins_E),
                   dst_of(ins_M), tnew_m(ins_M))) begin
      data_stall = 1'b1;
    end
  end

  // Busy counter: a start op in E loads the latency, then counts down to 0.
  // E is never held, so a start op occupies E for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (mult_E) begin
      cnt <= MULT_N;
    end else if (div_E) begin
      cnt <= DIV_N;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // All outputs are gated by rst so they read 0 throughout reset.
  assign mdu_busy = rst && (mult_E || div_E || (cnt != 4'd0));
  assign stall    = rst && (data_stall || (mdu_op_D && mdu_busy));
  assign stall_F  = stall;
  assign stall_D  = stall;
  assign flush_E  = stall;

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (stat_clr) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // Instruction fields that play no part in hazard detection.
  logic unused_fields;
  assign unused_fields = ^{ins_D[15:6], ins_E[25:21], ins_E[10:6],
                           ins_M[25:21], ins_M[10:6]};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Each task drives D/E/M
// vectors one cycle at a time and compares the outputs against
// hand-computed values.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] ins_D;
  logic [31:0] ins_E;
  logic [31:0] ins_M;
  logic        stall_F;
  logic        stall_D;
  logic        flush_E;
  logic        mdu_busy;
`ifdef HAZARD_STAT_EN
  logic        stat_clr;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .ins_D    (ins_D),
    .ins_E    (ins_E),
    .ins_M    (ins_M),
`ifdef HAZARD_STAT_EN
    .stat_clr (stat_clr),
    .stall_cnt(stall_cnt),
`endif
    .stall_F  (stall_F),
    .stall_D  (stall_D),
    .flush_E  (flush_E),
    .mdu_busy (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rt_ins(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] it_ins(input int op, input int rs, input int rt);
    return {6'(op), 5'(rs), 5'(rt), 16'h0000};
  endfunction

  logic [31:0] LW2, LW5, LW0, ADDU_3_2_4, ADDU_5_1_1, ADDU_3_0_0, BEQ_5_0;
  logic [31:0] DIV_1_2, MULT_1_2, MFLO_6, SW_2_0, SW_2_2, JAL, ADDU_3_31_0, ADDIU_5;

  // Apply one cycle's worth of inputs just after the rising edge.
  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    @(posedge clk);
    #1;
    ins_D = d;
    ins_E = e;
    ins_M = m;
    #1;
  endtask

  task automatic test_reset;
    drive(ADDU_3_2_4, LW2, 32'h0);
    checks++;
    if ({stall_F, stall_D, flush_E} !== 3'b000) begin
      errors++; $display("FAIL reset_stall got %b expected 000", {stall_F, stall_D, flush_E});
    end
    drive(MFLO_6, MULT_1_2, 32'h0);
    checks++;
    if ({stall_F, stall_D, flush_E, mdu_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_mdu got %b expected 0000", {stall_F, stall_D, flush_E, mdu_busy});
    end
    drive(32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    checks++;
    if ({stall_D, mdu_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_release got %b expected 00", {stall_D, mdu_busy});
    end
  endtask

  task automatic test_load_use;
    logic [31:0] vd [3];
    logic [31:0] ve [3];
    logic [31:0] vm [3];
    logic        vs [3];
    vd = '{ADDU_3_2_4, ADDU_3_2_4, 32'h0};
    ve = '{LW2,        32'h0,      ADDU_3_2_4};
    vm = '{32'h0,      LW2,        32'h0};
    vs = '{1'b1,       1'b0,       1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(vd[i], ve[i], vm[i]);
      checks++;
      if ({stall_F, stall_D, flush_E} !== {3{vs[i]}}) begin
        errors++; $display("FAIL load_use[%0d] got %b expected %b", i, {stall_F, stall_D, flush_E}, {3{vs[i]}});
      end
    end
  endtask

  task automatic test_branch_alu;
    logic [31:0] vd [2];
    logic [31:0] ve [2];
    logic [31:0] vm [2];
    logic        vs [2];
    vd = '{BEQ_5_0,    BEQ_5_0};
    ve = '{ADDU_5_1_1, 32'h0};
    vm = '{32'h0,      ADDU_5_1_1};
    vs = '{1'b1,       1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(vd[i], ve[i], vm[i]);
      checks++;
      if (stall_D !== vs[i] || flush_E !== vs[i]) begin
        errors++; $display("FAIL branch_alu[%0d] got %b%b expected %b", i, stall_D, flush_E, vs[i]);
      end
    end
  endtask

  task automatic test_branch_load;
    logic [31:0] vd [3];
    logic [31:0] ve [3];
    logic [31:0] vm [3];
    logic        vs [3];
    vd = '{BEQ_5_0, BEQ_5_0, BEQ_5_0};
    ve = '{LW5,     32'h0,   32'h0};
    vm = '{32'h0,   LW5,     32'h0};
    vs = '{1'b1,    1'b1,    1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(vd[i], ve[i], vm[i]);
      checks++;
      if (stall_D !== vs[i] || stall_F !== vs[i]) begin
        errors++; $display("FAIL branch_load[%0d] got %b%b expected %b", i, stall_F, stall_D, vs[i]);
      end
    end
  endtask

  // $0 destination, store data, jal and ALU-in-M cases.
  task automatic test_misc_cases;
    logic [31:0] vd [5];
    logic [31:0] ve [5];
    logic [31:0] vm [5];
    logic        vs [5];
    vd = '{ADDU_3_0_0, SW_2_0, SW_2_2, ADDU_3_31_0, BEQ_5_0};
    ve = '{LW0,        LW2,    LW2,    JAL,         32'h0};
    vm = '{32'h0,      32'h0,  32'h0,  32'h0,       ADDIU_5};
    vs = '{1'b0,       1'b0,   1'b1,   1'b0,        1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(vd[i], ve[i], vm[i]);
      checks++;
      if (stall_D !== vs[i]) begin
        errors++; $display("FAIL misc[%0d] got %b expected %b", i, stall_D, vs[i]);
      end
    end
  endtask

  // div in E at cycle 0, mflo in D from cycle 1: busy cycles 0..10,
  // stall cycles 1..10, released at cycle 11, mflo in E at cycle 12.
  task automatic test_mdu_div;
    logic exp_busy;
    logic exp_stall;
    drive(32'h0, DIV_1_2, 32'h0);
    checks++;
    if (mdu_busy !== 1'b1 || stall_D !== 1'b0) begin
      errors++; $display("FAIL div_start busy=%b stall=%b expected 1 0", mdu_busy, stall_D);
    end
    for (int c = 1; c <= 11; c++) begin
      drive(MFLO_6, 32'h0, (c == 1) ? DIV_1_2 : 32'h0);
      exp_busy  = (c <= 10);
      exp_stall = (c <= 10);
      checks++;
      if (mdu_busy !== exp_busy || {stall_F, stall_D, flush_E} !== {3{exp_stall}}) begin
        errors++; $display("FAIL div_wait[%0d] busy=%b stall=%b expected %b %b",
                           c, mdu_busy, stall_D, exp_busy, exp_stall);
      end
    end
    drive(32'h0, MFLO_6, 32'h0);
    checks++;
    if (mdu_busy !== 1'b0 || stall_D !== 1'b0) begin
      errors++; $display("FAIL div_done busy=%b stall=%b expected 0 0", mdu_busy, stall_D);
    end
  endtask

  // mult in E together with mflo in D: stall cycles 0..5, released at 6.
  task automatic test_mdu_mult_simul;
    logic exp_s;
    for (int c = 0; c <= 6; c++) begin
      drive(MFLO_6, (c == 0) ? MULT_1_2 : 32'h0, 32'h0);
      exp_s = (c <= 5);
      checks++;
      if (mdu_busy !== exp_s || stall_D !== exp_s) begin
        errors++; $display("FAIL mult_simul[%0d] busy=%b stall=%b expected %b",
                           c, mdu_busy, stall_D, exp_s);
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    drive(32'h0, MULT_1_2, 32'h0);
    drive(32'h0, 32'h0, MULT_1_2);
    drive(MFLO_6, 32'h0, 32'h0);
    checks++;
    if (mdu_busy !== 1'b1 || stall_D !== 1'b1) begin
      errors++; $display("FAIL mid_busy_pre busy=%b stall=%b expected 1 1", mdu_busy, stall_D);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_F, stall_D, flush_E, mdu_busy} !== 4'b0000) begin
      errors++; $display("FAIL mid_busy_rst got %b expected 0000", {stall_F, stall_D, flush_E, mdu_busy});
    end
    drive(32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    drive(MFLO_6, 32'h0, 32'h0);
    checks++;
    if (mdu_busy !== 1'b0 || stall_D !== 1'b0) begin
      errors++; $display("FAIL mid_busy_release busy=%b stall=%b expected 0 0", mdu_busy, stall_D);
    end
    drive(32'h0, MULT_1_2, 32'h0);
    checks++;
    if (mdu_busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy_restart busy=%b expected 1", mdu_busy);
    end
    for (int c = 0; c < 6; c++) drive(32'h0, 32'h0, 32'h0);
  endtask

`ifdef HAZARD_STAT_EN
  task automatic test_stall_stat;
    drive(32'h0, 32'h0, 32'h0);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    for (int c = 0; c < 3; c++) drive(ADDU_3_2_4, LW2, 32'h0);
    drive(32'h0, 32'h0, 32'h0);
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++; $display("FAIL stat_wrap got %h expected 00000001", stall_cnt);
    end
    drive(ADDU_3_2_4, LW2, 32'h0);
    stat_clr = 1'b1;
    drive(32'h0, 32'h0, 32'h0);
    stat_clr = 1'b0;
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL stat_clr got %h expected 00000000", stall_cnt);
    end
  endtask
`endif

  initial begin
    LW2         = it_ins(6'h23, 0, 2);
    LW5         = it_ins(6'h23, 0, 5);
    LW0         = it_ins(6'h23, 0, 0);
    SW_2_0      = it_ins(6'h2B, 0, 2);
    SW_2_2      = it_ins(6'h2B, 2, 2);
    BEQ_5_0     = it_ins(6'h04, 5, 0);
    JAL         = {6'h03, 26'h0000100};
    ADDIU_5     = it_ins(6'h09, 1, 5);
    ADDU_3_2_4  = rt_ins(2, 4, 3, 6'h21);
    ADDU_5_1_1  = rt_ins(1, 1, 5, 6'h21);
    ADDU_3_0_0  = rt_ins(0, 0, 3, 6'h21);
    ADDU_3_31_0 = rt_ins(31, 0, 3, 6'h21);
    DIV_1_2     = rt_ins(1, 2, 0, 6'h1A);
    MULT_1_2    = rt_ins(1, 2, 0, 6'h18);
    MFLO_6      = rt_ins(0, 0, 6, 6'h12);
    rst   = 1'b0;
    ins_D = 32'h0;
    ins_E = 32'h0;
    ins_M = 32'h0;
`ifdef HAZARD_STAT_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_misc_cases();
    test_mdu_div();
    test_mdu_mult_simul();
    test_reset_mid_busy();
`ifdef HAZARD_STAT_EN
    test_stall_stat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
